// File: rtl/pila_param_pkg.sv
// Shared stack definitions: WRAP mode encoding, operation decode and the clog2 helper.
// Pure constants and functions; no state, no latency, no flow control.
package pila_param_pkg;

    localparam int WRAP_REJECT    = 0;
    localparam int WRAP_OVERWRITE = 1;

    typedef enum logic [1:0] {
        OP_IDLE    = 2'b00,
        OP_POP     = 2'b01,
        OP_PUSH    = 2'b10,
        OP_REPLACE = 2'b11
    } stk_op_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic stk_op_e decode_op(input logic push, input logic pop);
        stk_op_e op;
        case ({push, pop})
            2'b10:   op = OP_PUSH;
            2'b01:   op = OP_POP;
            2'b11:   op = OP_REPLACE;
            default: op = OP_IDLE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/pila_param_mem.sv
// Stack storage: DEPTH x WIDTH array, one synchronous write port, one asynchronous read port.
// Write lands on the rising edge; read is combinational; never stalls. Contents are not reset.
module pila_mem
    import pila_param_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8,
    localparam int AW   = clog2(DEPTH)
)(
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/pila_param.sv
// Parameterised LIFO (return-address stack) with show-ahead top, sticky overflow/underflow.
// Push visible on top next cycle, pop is zero-latency; never stalls (full/empty push/pop flagged).
module pila_param
    import pila_param_pkg::*;
#(
    parameter int WIDTH  = 10,
    parameter int DEPTH  = 8,
    parameter int WRAP   = WRAP_REJECT,
    localparam int CNT_W = clog2(DEPTH + 1),
    localparam int AW    = clog2(DEPTH)
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             clr_err,
    input  logic [WIDTH-1:0] inpush,
    output logic [WIDTH-1:0] top,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    logic [AW-1:0]    tos_q, tos_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic [AW-1:0]    tos_inc, tos_dec;
    logic             is_empty, is_full;
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_rdata;
    stk_op_e          op;

    assign op       = decode_op(push, pop);
    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CNT_W'(DEPTH));

    // Explicit wrap so non-power-of-two depths index correctly.
    assign tos_inc = (tos_q == AW'(DEPTH - 1)) ? '0 : tos_q + AW'(1);
    assign tos_dec = (tos_q == '0) ? AW'(DEPTH - 1) : tos_q - AW'(1);

    always_comb begin
        tos_d       = tos_q;
        count_d     = count_q;
        overflow_d  = clr_err ? 1'b0 : overflow_q;
        underflow_d = clr_err ? 1'b0 : underflow_q;
        mem_we      = 1'b0;
        mem_waddr   = tos_q;

        case (op)
            OP_PUSH: begin
                if (!is_full) begin
                    tos_d     = tos_inc;
                    count_d   = count_q + CNT_W'(1);
                    mem_we    = 1'b1;
                    mem_waddr = tos_inc;
                end else begin
                    overflow_d = 1'b1;
                    // In overwrite mode the slot after tos holds the oldest entry.
                    if (WRAP == WRAP_OVERWRITE) begin
                        tos_d     = tos_inc;
                        mem_we    = 1'b1;
                        mem_waddr = tos_inc;
                    end
                end
            end
            OP_POP: begin
                if (!is_empty) begin
                    tos_d   = tos_dec;
                    count_d = count_q - CNT_W'(1);
                end else begin
                    underflow_d = 1'b1;
                end
            end
            OP_REPLACE: begin
                if (!is_empty) begin
                    mem_we    = 1'b1;
                    mem_waddr = tos_q;
                end else begin
                    tos_d     = tos_inc;
                    count_d   = CNT_W'(1);
                    mem_we    = 1'b1;
                    mem_waddr = tos_inc;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tos_q       <= AW'(DEPTH - 1);
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            tos_q       <= tos_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    pila_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we & ~reset),
        .waddr (mem_waddr),
        .wdata (inpush),
        .raddr (tos_q),
        .rdata (mem_rdata)
    );

    assign top       = is_empty ? '0 : mem_rdata;
    assign count     = count_q;
    assign empty     = is_empty;
    assign full      = is_full;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule
